// File: rtl/program_loader.sv
// Boot loader: receives a big-endian length header and program words over a
// byte stream, writes them to instruction memory and releases the CPU reset.
module program_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd2097152,
    parameter int          MAX_WORDS = 1024,
    parameter int          TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        ins_mem_write,
    output logic [31:0] instruction_to_write,
    output logic [31:0] ins_addr,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] words_loaded
);

    localparam int              TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]     MAX_LEN = 32'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       index_q, index_d;
    logic [TO_W-1:0]   timeout_q, timeout_d;
    logic [15:0]       words_loaded_q, words_loaded_d;
    logic [31:0]       instr_q, instr_d;
    logic [31:0]       addr_q, addr_d;
    logic              wr_q, wr_d;
    logic              rx_ready_q, rx_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_rst_q, cpu_rst_d;

    logic              xfer;
    logic [31:0]       full_word;

    // rx_ready_q is a pure decode of the current state, so it is safe to use
    // as the handshake qualifier here.
    assign xfer      = rx_valid && rx_ready_q;
    assign full_word = {shift_q, rx_data};

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        shift_d        = shift_q;
        len_d          = len_q;
        index_d        = index_q;
        timeout_d      = timeout_q;
        words_loaded_d = words_loaded_q;
        instr_d        = instr_q;
        addr_d         = addr_q;
        wr_d           = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d        = S_HDR;
                    byte_cnt_d     = 2'd0;
                    index_d        = 32'd0;
                    words_loaded_d = 16'd0;
                    timeout_d      = '0;
                end
            end
            S_HDR, S_DATA: begin
                if (xfer) begin
                    timeout_d  = '0;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    shift_d    = {shift_q[15:0], rx_data};
                    if (byte_cnt_q == 2'd3) begin
                        if (state_q == S_HDR) begin
                            len_d   = full_word;
                            state_d = (full_word == 32'd0 || full_word > MAX_LEN) ? S_ERR : S_DATA;
                        end else begin
                            // Write strobe and payload are registered on entry to WR.
                            instr_d = full_word;
                            addr_d  = BASE_ADDR + index_q;
                            wr_d    = 1'b1;
                            state_d = S_WR;
                        end
                    end
                end else if (timeout_q == TO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    timeout_d = timeout_q + 1'b1;
                end
            end
            S_WR: begin
                index_d        = index_q + 32'd1;
                words_loaded_d = words_loaded_q + 16'd1;
                state_d        = (index_q + 32'd1 == len_q) ? S_DONE : S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_HDR) || (state_d == S_DATA);
        busy_d     = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_WR);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERR);
        cpu_rst_d  = (state_d != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            byte_cnt_q     <= 2'd0;
            shift_q        <= 24'd0;
            len_q          <= 32'd0;
            index_q        <= 32'd0;
            timeout_q      <= '0;
            words_loaded_q <= 16'd0;
            instr_q        <= 32'd0;
            addr_q         <= 32'd0;
            wr_q           <= 1'b0;
            rx_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            shift_q        <= shift_d;
            len_q          <= len_d;
            index_q        <= index_d;
            timeout_q      <= timeout_d;
            words_loaded_q <= words_loaded_d;
            instr_q        <= instr_d;
            addr_q         <= addr_d;
            wr_q           <= wr_d;
            rx_ready_q     <= rx_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
            cpu_rst_q      <= cpu_rst_d;
        end
    end

    assign rx_ready             = rx_ready_q;
    assign ins_mem_write        = wr_q;
    assign instruction_to_write = instr_q;
    assign ins_addr             = addr_q;
    assign cpu_rst              = cpu_rst_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign err                  = err_q;
    assign words_loaded         = words_loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued by the
// stimulus and matched by a negedge monitor; status outputs checked inline.
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready;
    logic        ins_mem_write;
    logic [31:0] instruction_to_write;
    logic [31:0] ins_addr;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    program_loader #(
        .BASE_ADDR(BASE),
        .MAX_WORDS(1024),
        .TIMEOUT  (8)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .rx_valid            (rx_valid),
        .rx_data             (rx_data),
        .rx_ready            (rx_ready),
        .ins_mem_write       (ins_mem_write),
        .instruction_to_write(instruction_to_write),
        .ins_addr            (ins_addr),
        .cpu_rst             (cpu_rst),
        .busy                (busy),
        .done                (done),
        .err                 (err),
        .words_loaded        (words_loaded)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (ins_mem_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                         ins_addr, instruction_to_write);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", ins_addr, mon_e[63:32]);
                check("wr_data", instruction_to_write, mon_e[31:0]);
                check_bit("rx_ready_in_wr", rx_ready, 1'b0);
                $display("write addr=0x%08h data=0x%08h", ins_addr, instruction_to_write);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        guard    = 0;
        while (!rx_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL rx_ready_wait: got rx_ready=0 for 40 cycles expected 1");
        end
        @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic rx_idle();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int guard;
        guard = 0;
        while (!(done || err) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!(done || err)) begin
            checks++;
            errors++;
            $display("FAIL %s_end_wait: got done=0 err=0 after 40 cycles expected done or err", name);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_rx_ready"}, rx_ready, 1'b0);
        check_bit({tag, "_ins_mem_write"}, ins_mem_write, 1'b0);
        check({tag, "_instruction"}, instruction_to_write, 32'h0);
        check({tag, "_ins_addr"}, ins_addr, 32'h0);
        check_bit({tag, "_cpu_rst"}, cpu_rst, 1'b1);
        check_bit({tag, "_busy"}, busy, 1'b0);
        check_bit({tag, "_done"}, done, 1'b0);
        check_bit({tag, "_err"}, err, 1'b0);
        check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Two-word load.
        do_start();
        exp_q.push_back({BASE,         32'h1234_5678});
        exp_q.push_back({BASE + 32'd1, 32'h9ABC_DEF0});
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_word(32'h9ABC_DEF0);
        rx_idle();
        wait_end("two_word");
        check_bit("two_word_done", done, 1'b1);
        check_bit("two_word_err", err, 1'b0);
        check_bit("two_word_cpu_rst", cpu_rst, 1'b0);
        check_bit("two_word_busy", busy, 1'b0);
        check("two_word_words_loaded", 32'(words_loaded), 32'd2);
        check("two_word_addr_hold", ins_addr, BASE + 32'd1);
        check("two_word_data_hold", instruction_to_write, 32'h9ABC_DEF0);
        $display("load 2 words: done=%b words_loaded=%0d", done, words_loaded);

        // Zero-length header, then a valid single-word load.
        do_start();
        check_bit("restart_busy", busy, 1'b1);
        check_bit("restart_cpu_rst", cpu_rst, 1'b1);
        send_word(32'd0);
        rx_idle();
        wait_end("zero_len");
        check_bit("zero_len_err", err, 1'b1);
        check_bit("zero_len_cpu_rst", cpu_rst, 1'b1);
        check_bit("zero_len_done", done, 1'b0);
        $display("zero-length header: err=%b", err);
        do_start();
        check_bit("err_cleared_by_start", err, 1'b0);
        exp_q.push_back({BASE, 32'hCAFE_F00D});
        send_word(32'd1);
        send_word(32'hCAFE_F00D);
        rx_idle();
        wait_end("one_word");
        check_bit("one_word_done", done, 1'b1);
        check("one_word_words_loaded", 32'(words_loaded), 32'd1);
        $display("load 1 word: done=%b", done);

        // Oversized header.
        do_start();
        send_word(32'h0000_0401);
        rx_idle();
        wait_end("too_long");
        check_bit("too_long_err", err, 1'b1);
        check_bit("too_long_busy", busy, 1'b0);
        check("too_long_words_loaded", 32'(words_loaded), 32'd0);
        $display("header 1025: err=%b", err);

        // Three words with rx_valid held high throughout.
        do_start();
        exp_q.push_back({BASE,         32'h1122_3344});
        exp_q.push_back({BASE + 32'd1, 32'hA5A5_5A5A});
        exp_q.push_back({BASE + 32'd2, 32'h0BAD_F00D});
        send_word(32'd3);
        send_word(32'h1122_3344);
        send_word(32'hA5A5_5A5A);
        send_word(32'h0BAD_F00D);
        rx_idle();
        wait_end("streamed");
        check_bit("streamed_done", done, 1'b1);
        check("streamed_words_loaded", 32'(words_loaded), 32'd3);
        $display("streamed 3 words: done=%b words_loaded=%0d", done, words_loaded);

        // Stall mid-word: err exactly 8 cycles after the last accepted byte.
        do_start();
        send_word(32'd1);
        send_byte(8'hAB);
        send_byte(8'hCD);
        rx_idle();
        repeat (7) @(negedge clk);
        check_bit("timeout_err_early", err, 1'b0);
        @(negedge clk);
        check_bit("timeout_err", err, 1'b1);
        check("timeout_words_loaded", 32'(words_loaded), 32'd0);
        check_bit("timeout_cpu_rst", cpu_rst, 1'b1);
        $display("stall: err=%b", err);

        // Reset during the WR cycle of word 2 of 3.
        do_start();
        exp_q.push_back({BASE,         32'h0102_0304});
        exp_q.push_back({BASE + 32'd1, 32'hF0E0_D0C0});
        send_word(32'd3);
        send_word(32'h0102_0304);
        send_word(32'hF0E0_D0C0);
        @(negedge clk);
        check_bit("mid_wr_strobe", ins_mem_write, 1'b1);
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_wr_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("post_reset_idle_busy", busy, 1'b0);
        check_bit("post_reset_idle_ready", rx_ready, 1'b0);
        $display("reset in WR: cpu_rst=%b busy=%b", cpu_rst, busy);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
